// File: rtl/line_clear.sv
// rtl/line_clear.sv - full-row scan, shift-down and top-row clear after a piece locks (LINE_CLEAR_SCORE_EN adds score)
module line_clear #(
  parameter int BOARD_W  = 10,
  parameter int BOARD_H  = 20,
  parameter int ADDR_W   = 8,
  parameter int COLOUR_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [COLOUR_W-1:0] ram_Q,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [COLOUR_W-1:0] ram_data,
  output logic                wren,
  output logic [2:0]          lines_cleared,
  output logic                complete
`ifdef LINE_CLEAR_SCORE_EN
  ,
  output logic [15:0]         score
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_EVAL,
    S_SHIFT,
    S_CLEAR,
    S_DONE
  } state_t;

  localparam logic [3:0] X_LAST     = 4'(BOARD_W - 1);
  localparam logic [3:0] X_SCAN_END = 4'(BOARD_W);
  localparam logic [4:0] ROW_BOTTOM = 5'(BOARD_H - 1);

  state_t     state, state_nxt;
  logic [4:0] row;
  logic [4:0] dst;
  logic [3:0] x;
  logic       phase;   // 0: read source cell, 1: write destination cell
  logic       full;    // stays 1 while every captured cell of the row is nonzero
  logic [2:0] count;
  logic       armed;   // enable has been seen low since the last completed run

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] r, input logic [3:0] c);
    logic [15:0] a;
    a = 16'(r) * 16'(BOARD_W) + 16'(c);
    return a[ADDR_W-1:0];
  endfunction

`ifdef LINE_CLEAR_SCORE_EN
  logic [15:0] score_add;
  logic [16:0] score_sum;

  // Points for the number of rows removed in this run, with saturating sum
  always_comb begin
    score_add = 16'd0;
    case (count)
      3'd0:    score_add = 16'd0;
      3'd1:    score_add = 16'd40;
      3'd2:    score_add = 16'd100;
      3'd3:    score_add = 16'd300;
      default: score_add = 16'd1200;
    endcase
    score_sum = {1'b0, score} + {1'b0, score_add};
  end
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state and RAM port drive; dropping enable mid-run aborts to IDLE
  always_comb begin
    state_nxt = state;
    ram_addr  = '0;
    ram_data  = '0;
    wren      = 1'b0;
    complete  = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable && armed) state_nxt = S_SCAN;
      end
      S_SCAN: begin
        ram_addr = cell_addr(row, x);
        if (x == X_SCAN_END) state_nxt = S_EVAL;
      end
      S_EVAL: begin
        if (full)             state_nxt = (row == 5'd0) ? S_CLEAR : S_SHIFT;
        else if (row != 5'd0) state_nxt = S_SCAN;
        else                  state_nxt = S_DONE;
      end
      S_SHIFT: begin
        if (!phase) begin
          ram_addr = cell_addr(dst - 5'd1, x);
        end else begin
          ram_addr = cell_addr(dst, x);
          ram_data = ram_Q;
          wren     = 1'b1;
          if (x == X_LAST && dst == 5'd1) state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        ram_addr = cell_addr(5'd0, x);
        wren     = 1'b1;
        if (x == X_LAST) state_nxt = S_SCAN;
      end
      S_DONE: begin
        complete  = enable;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (state != S_IDLE && !enable) state_nxt = S_IDLE;
  end

  // Row/column counters, full-row detection, line count and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row           <= 5'd0;
      dst           <= 5'd0;
      x             <= 4'd0;
      phase         <= 1'b0;
      full          <= 1'b0;
      count         <= 3'd0;
      armed         <= 1'b1;
      lines_cleared <= 3'd0;
`ifdef LINE_CLEAR_SCORE_EN
      score         <= 16'd0;
`endif
    end else begin
      if (!enable) armed <= 1'b1;
      case (state)
        S_IDLE: begin
          if (enable && armed) begin
            row   <= ROW_BOTTOM;
            count <= 3'd0;
            x     <= 4'd0;
            full  <= 1'b1;
            armed <= 1'b0;
          end
        end
        S_SCAN: begin
          // ram_Q lags the address by one cycle, so capture starts at x = 1
          if (x != 4'd0) full <= full & (ram_Q != '0);
          x <= x + 4'd1;
        end
        S_EVAL: begin
          x     <= 4'd0;
          phase <= 1'b0;
          if (full) begin
            if (count != 3'd7) count <= count + 3'd1;
            dst <= row;
          end else if (row != 5'd0) begin
            row  <= row - 5'd1;
            full <= 1'b1;
          end
        end
        S_SHIFT: begin
          phase <= ~phase;
          if (phase) begin
            if (x == X_LAST) begin
              x   <= 4'd0;
              dst <= dst - 5'd1;
            end else begin
              x <= x + 4'd1;
            end
          end
        end
        S_CLEAR: begin
          // Rescan the same row afterwards: the row shifted into it may be full too
          if (x == X_LAST) begin
            x    <= 4'd0;
            full <= 1'b1;
          end else begin
            x <= x + 4'd1;
          end
        end
        S_DONE: begin
          if (enable) begin
            lines_cleared <= count;
`ifdef LINE_CLEAR_SCORE_EN
            score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_line_clear.sv
// tb/tb_line_clear.sv - self-checking bench for line_clear against a row-level board model
module tb_line_clear;

  localparam int W = 10;
  localparam int H = 20;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [5:0] ram_Q;
  logic [7:0] ram_addr;
  logic [5:0] ram_data;
  logic       wren;
  logic [2:0] lines_cleared;
  logic       complete;
`ifdef LINE_CLEAR_SCORE_EN
  logic [15:0] score;
  int          score_exp = 0;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int exp_done = -1;
  bit done_seen = 1'b0;
  bit chk_on    = 1'b0;

  logic [5:0] mem      [0:255];
  logic [5:0] init_mem [0:255];
  logic       load;

  int exp_board [0:N-1];
  int wq_a [$];
  int wq_d [$];

  line_clear dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .ram_Q         (ram_Q),
    .ram_addr      (ram_addr),
    .ram_data      (ram_data),
    .wren          (wren),
    .lines_cleared (lines_cleared),
    .complete      (complete)
`ifdef LINE_CLEAR_SCORE_EN
    ,
    .score         (score)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Board RAM: synchronous read, old data on read-during-write
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_mem[i];
    end else if (wren) begin
      mem[ram_addr] <= ram_data;
    end
    ram_Q <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Row-level reference: full rows removed bottom-up, writes listed in issue order
  task automatic model_run(output int cycles, output int lc);
    int  r;
    bit  f;
    bit  fin;
    cycles = 0;
    lc     = 0;
    r      = H - 1;
    fin    = 1'b0;
    while (!fin) begin
      cycles += W + 2;
      f = 1'b1;
      for (int c = 0; c < W; c++) if (exp_board[r*W + c] == 0) f = 1'b0;
      if (f) begin
        if (lc < 7) lc++;
        for (int d = r; d >= 1; d--) begin
          for (int c = 0; c < W; c++) begin
            exp_board[d*W + c] = exp_board[(d-1)*W + c];
            wq_a.push_back(d*W + c);
            wq_d.push_back(exp_board[d*W + c]);
          end
        end
        for (int c = 0; c < W; c++) begin
          exp_board[c] = 0;
          wq_a.push_back(c);
          wq_d.push_back(0);
        end
        cycles += 2*W*r + W;
      end else if (r == 0) begin
        fin = 1'b1;
      end else begin
        r--;
      end
    end
  endtask

  task automatic arm_model(output int tot, output int lc, output int nw);
    for (int i = 0; i < N; i++) exp_board[i] = int'(mem[i]);
    wq_a.delete();
    wq_d.delete();
    model_run(tot, lc);
    nw = wq_a.size();
  endtask

  task automatic load_board();
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic clear_init();
    for (int i = 0; i < 256; i++) init_mem[i] = 6'd0;
  endtask

  function automatic int count_nz_except(input int skip);
    int n;
    n = 0;
    for (int i = 0; i < N; i++) if (i != skip && mem[i] != 6'd0) n++;
    return n;
  endfunction

  task automatic do_run(input string tag, input bit rel_reset, output int tot, output int lc, output int nw);
    int errs;
    arm_model(tot, lc, nw);
`ifdef LINE_CLEAR_SCORE_EN
    begin
      int add;
      add = (lc == 0) ? 0 : (lc == 1) ? 40 : (lc == 2) ? 100 : (lc == 3) ? 300 : 1200;
      score_exp = (score_exp + add > 65535) ? 65535 : score_exp + add;
    end
`endif
    @(negedge clk);
    if (rel_reset) reset = 1'b0;
    done_seen = 1'b0;
    exp_done  = cyc + 1 + tot;
    enable    = 1'b1;
    for (int i = 0; i < tot + 50 && !done_seen; i++) @(negedge clk);
    chk({tag, "_done"}, 32'(done_seen), 32'd1);
    @(negedge clk);
    chk({tag, "_lines"}, 32'(lines_cleared), 32'(lc));
    errs = 0;
    for (int i = 0; i < N; i++) if (int'(mem[i]) != exp_board[i]) errs++;
    chk({tag, "_board_errs"}, 32'(errs), 32'd0);
    chk({tag, "_missing_writes"}, 32'(wq_a.size()), 32'd0);
`ifdef LINE_CLEAR_SCORE_EN
    chk({tag, "_score"}, 32'(score), 32'(score_exp));
`endif
    repeat (5) @(negedge clk);
    exp_done = -1;
    enable   = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Every-cycle compare: complete timing and each RAM write against the model queue
  initial begin
    int ea, ed;
    forever begin
      @(negedge clk);
      if (chk_on && !reset) begin
        chk("complete_timing", 32'(complete), 32'(cyc == exp_done));
        if (complete) done_seen = 1'b1;
        if (wren) begin
          if (wq_a.size() == 0) begin
            chk("unexpected_write", 32'(wren), 32'd0);
          end else begin
            ea = wq_a.pop_front();
            ed = wq_d.pop_front();
            chk("write_addr", 32'(ram_addr), 32'(ea));
            chk("write_data", 32'(ram_data), 32'(ed));
          end
        end
      end
    end
  end

  initial begin
    int tot, lc, nw, k;
`ifdef LINE_CLEAR_SCORE_EN
    int s_before;
`endif
    reset  = 1'b1;
    enable = 1'b0;
    load   = 1'b0;
    clear_init();
    repeat (3) @(negedge clk);
    chk("rst_wren", 32'(wren), 32'd0);
    chk("rst_complete", 32'(complete), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_data", 32'(ram_data), 32'd0);
    chk("rst_lines", 32'(lines_cleared), 32'd0);
    reset  = 1'b0;
    chk_on = 1'b1;

    // Empty board
    clear_init();
    load_board();
    do_run("empty", 1'b0, tot, lc, nw);
    chk("empty_cycles", 32'(tot), 32'd240);
    chk("empty_nwrites", 32'(nw), 32'd0);
    chk("empty_lines_lit", 32'(lines_cleared), 32'd0);

    // Single full bottom row
    clear_init();
    for (int c = 0; c < W; c++) init_mem[190 + c] = 6'h05;
    init_mem[183] = 6'h2A;
    load_board();
    do_run("single", 1'b0, tot, lc, nw);
    chk("single_cycles", 32'(tot), 32'd642);
    chk("single_lines_lit", 32'(lines_cleared), 32'd1);
    chk("single_addr193", 32'(mem[193]), 32'h2A);
    chk("single_others", 32'(count_nz_except(193)), 32'd0);

    // Four full rows
    clear_init();
    for (int i = 160; i < 200; i++) init_mem[i] = 6'h05;
    init_mem[150] = 6'h11;
    load_board();
`ifdef LINE_CLEAR_SCORE_EN
    s_before = int'(score);
`endif
    do_run("four", 1'b0, tot, lc, nw);
    chk("four_cycles", 32'(tot), 32'd1848);
    chk("four_lines_lit", 32'(lines_cleared), 32'd4);
    chk("four_addr190", 32'(mem[190]), 32'h11);
    chk("four_others", 32'(count_nz_except(190)), 32'd0);
`ifdef LINE_CLEAR_SCORE_EN
    chk("four_score_lit", 32'(score), 32'(s_before + 1200));
`endif

    // Only row 0 full
    clear_init();
    for (int c = 0; c < W; c++) init_mem[c] = 6'($urandom_range(1, 63));
    load_board();
    do_run("row0", 1'b0, tot, lc, nw);
    chk("row0_cycles", 32'(tot), 32'd262);
    chk("row0_nwrites", 32'(nw), 32'd10);
    chk("row0_lines_lit", 32'(lines_cleared), 32'd1);
    chk("row0_empty", 32'(count_nz_except(-1)), 32'd0);

    // Enable dropped during SHIFT
    clear_init();
    for (int c = 0; c < W; c++) init_mem[190 + c] = 6'h07;
    load_board();
    arm_model(tot, lc, nw);
    @(negedge clk);
    exp_done = -1;
    enable   = 1'b1;
    k = 0;
    while (!wren && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("abort_saw_write", 32'(wren), 32'd1);
    enable = 1'b0;
    @(negedge clk);
    chk("abort_wren_next", 32'(wren), 32'd0);
    chk("abort_no_complete", 32'(complete), 32'd0);
    chk("abort_lines_kept", 32'(lines_cleared), 32'd1);
    repeat (3) @(negedge clk);
    chk("abort_wren_idle", 32'(wren), 32'd0);
    wq_a.delete();
    wq_d.delete();
    do_run("after_abort", 1'b0, tot, lc, nw);
    chk("after_abort_lines_lit", 32'(lc), 32'd0);

    // Reset during CLEAR_TOP, then a fresh run with enable held high
    clear_init();
    for (int c = 0; c < W; c++) init_mem[c] = 6'($urandom_range(1, 63));
    load_board();
    arm_model(tot, lc, nw);
    @(negedge clk);
    exp_done = -1;
    enable   = 1'b1;
    k = 0;
    while (!wren && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("rstclr_saw_write", 32'(wren), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rstclr_wren_async", 32'(wren), 32'd0);
    chk("rstclr_complete_async", 32'(complete), 32'd0);
    chk("rstclr_lines", 32'(lines_cleared), 32'd0);
    wq_a.delete();
    wq_d.delete();
`ifdef LINE_CLEAR_SCORE_EN
    score_exp = 0;
`endif
    do_run("post_reset", 1'b1, tot, lc, nw);
    chk("post_reset_lines_lit", 32'(lc), 32'd1);

    // Randomised boards
    for (int t = 0; t < 8; t++) begin
      clear_init();
      for (int r = 0; r < H; r++) begin
        int kind, hole;
        kind = int'($urandom_range(0, 3));
        hole = int'($urandom_range(0, W - 1));
        for (int c = 0; c < W; c++) begin
          case (kind)
            0:       init_mem[r*W + c] = 6'($urandom_range(1, 63));
            1:       init_mem[r*W + c] = (c == hole) ? 6'd0 : 6'($urandom_range(1, 63));
            default: init_mem[r*W + c] = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
          endcase
        end
      end
      load_board();
      do_run($sformatf("rand%0d", t), 1'b0, tot, lc, nw);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
